// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch unit.
//                Holds the fetch FSM state encoding, instruction width, PC
//                step, the NOP word loaded into IF/ID at reset, and the
//                width of the miss timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    MISS  = 1'b1
  } fetch_state_t;

  localparam int          INSTR_W   = 32;
  localparam logic [31:0] PC_STEP   = 32'd4;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  // Miss timer is 8 bits wide and saturates at its all-ones value.
  localparam int          TIMER_W   = 8;
  localparam logic [7:0]  TIMER_MAX = 8'hFF;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit_if
//  Description : Instruction-cache fetch bus between the fetch unit and the
//                instruction cache.
//                  ic_address : fetch address (driven by the fetch unit)
//                  ic_data    : instruction word, valid while ic_hit = 1
//                  ic_hit     : same-cycle hit indication for ic_address
//                Modports: master = fetch unit side, slave = cache side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic [31:0]        ic_address;
  logic [INSTR_W-1:0] ic_data;
  logic               ic_hit;

  modport master (
    output ic_address,
    input  ic_data,
    input  ic_hit
  );

  modport slave (
    input  ic_address,
    output ic_data,
    output ic_hit
  );

endinterface : instr_fetch_unit_if
`default_nettype wire

// File: rtl/fetch_perf_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_perf_ctr
//  Description : Saturating event counter. Increments by one on each clock
//                edge where inc = 1, sticks at all-ones, and clears on reset.
//  Ports       : clk   in  1      clock, rising edge
//                rst_n in  1      asynchronous active-low reset
//                inc   in  1      count enable for this cycle
//                count out CNT_W  current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_perf_ctr #(
  parameter int unsigned CNT_W = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             inc,
  output      logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : fetch_perf_ctr
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Initiator side of the instruction-cache fetch interface.
//                Owns the PC (driven straight onto ic_address), loads the
//                IF/ID register on a hit, holds the PC across misses, honours
//                decode stall and branch/jump redirects.
//                Per-edge priority: redirect > stall > hit/miss.
//  Ports       : clk            in  1      clock, rising edge
//                rst_n          in  1      asynchronous active-low reset
//                ic             master     cache bus (address/data/hit)
//                redirect_valid in  1      taken branch/jump pulse
//                redirect_pc    in  32     redirect target (bits [1:0] ignored)
//                stall_in       in  1      decode back-pressure
//                if_valid       out 1      IF/ID holds a valid instruction
//                if_instr       out 32     IF/ID instruction
//                if_pc          out 32     PC of if_instr
//                fetch_err      out 1      sticky miss-timeout flag
//                hit_count      out CNT_W  delivered instructions
//                miss_count     out CNT_W  miss episodes entered
//  Config      : FETCH_PERF_EN - when defined, hit_count/miss_count are live
//                saturating counters; otherwise both are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned MISS_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 16
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  instr_fetch_unit_if.master      ic,
  input  wire logic               redirect_valid,
  input  wire logic [31:0]        redirect_pc,
  input  wire logic               stall_in,
  output      logic               if_valid,
  output      logic [INSTR_W-1:0] if_instr,
  output      logic [31:0]        if_pc,
  output      logic               fetch_err,
  output      logic [CNT_W-1:0]   hit_count,
  output      logic [CNT_W-1:0]   miss_count
);

  localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(MISS_TIMEOUT);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [31:0]        if_pc_q, if_pc_d;
  logic               fetch_err_q, fetch_err_d;
  logic [TIMER_W-1:0] miss_timer_q, miss_timer_d;
  logic [TIMER_W-1:0] timer_inc;
  logic               deliver;
  logic               miss_start;

  assign timer_inc = (miss_timer_q == TIMER_MAX) ? TIMER_MAX
                                                 : miss_timer_q + TIMER_W'(1);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    fetch_err_d  = fetch_err_q;
    miss_timer_d = miss_timer_q;
    deliver      = 1'b0;
    miss_start   = 1'b0;

    if (redirect_valid) begin
      // The word currently on ic_data belongs to the wrong path: drop it.
      pc_d         = redirect_pc & ~32'd3;
      if_valid_d   = 1'b0;
      state_d      = FETCH;
      miss_timer_d = '0;
    end else if (stall_in) begin
      // Everything holds, but an outstanding miss keeps ageing.
      if (state_q == MISS) begin
        miss_timer_d = timer_inc;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (ic.ic_hit) begin
            deliver = 1'b1;
          end else begin
            state_d      = MISS;
            if_valid_d   = 1'b0;
            miss_timer_d = TIMER_W'(1);
            miss_start   = 1'b1;
          end
        end
        MISS: begin
          if (ic.ic_hit) begin
            deliver      = 1'b1;
            state_d      = FETCH;
            miss_timer_d = '0;
          end else begin
            if_valid_d   = 1'b0;
            miss_timer_d = timer_inc;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end

    if (deliver) begin
      if_instr_d = ic.ic_data;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_q + PC_STEP;
    end

    // Timer is zero whenever no miss is pending, so this only fires on a
    // miss that has lasted MISS_TIMEOUT cycles.
    if (miss_timer_d >= TIMEOUT_C) begin
      fetch_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= NOP;
      if_pc_q      <= '0;
      fetch_err_q  <= 1'b0;
      miss_timer_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      fetch_err_q  <= fetch_err_d;
      miss_timer_q <= miss_timer_d;
    end
  end

  assign ic.ic_address = pc_q;
  assign if_valid      = if_valid_q;
  assign if_instr      = if_instr_q;
  assign if_pc         = if_pc_q;
  assign fetch_err     = fetch_err_q;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr #(
    .CNT_W (CNT_W)
  ) u_hit_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (deliver),
    .count (hit_count)
  );

  fetch_perf_ctr #(
    .CNT_W (CNT_W)
  ) u_miss_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_start),
    .count (miss_count)
  );
`else
  logic perf_unused;
  assign perf_unused = deliver ^ miss_start;
  assign hit_count   = '0;
  assign miss_count  = '0;
`endif

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Directed stimulus
//                pushes the expected IF/ID PC into a queue for every cycle the
//                register should hold a valid instruction; a monitor pops and
//                compares whenever if_valid is seen. Address, error flag and
//                counters are checked directly after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hit_r = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall_in = 1'b0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_err;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Cache model: every address returns a recognisable word.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  instr_fetch_unit_if ic_bus ();
  assign ic_bus.ic_hit  = hit_r;
  assign ic_bus.ic_data = word_at(ic_bus.ic_address);

  instr_fetch_unit #(
    .RESET_PC     (32'h0000_0000),
    .MISS_TIMEOUT (4),
    .CNT_W        (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic             (ic_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_in       (stall_in),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_err      (fetch_err),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_cnt(input logic [15:0] hc, input logic [15:0] mc);
`ifdef FETCH_PERF_EN
    check32("hit_count", 32'(hit_count), 32'(hc));
    check32("miss_count", 32'(miss_count), 32'(mc));
`else
    check32("hit_count", 32'(hit_count), 32'(hc & 16'h0));
    check32("miss_count", 32'(miss_count), 32'(mc & 16'h0));
`endif
  endtask

  // One clock of stimulus; if push=1 the IF/ID register must show ppc after this edge.
  task automatic step(input logic h, input logic st, input logic rv,
                      input logic [31:0] rp, input bit push, input logic [31:0] ppc);
    hit_r          = h;
    stall_in       = st;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
    if (push) exp_q.push_back(ppc);
    redirect_valid = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : mon
    logic [31:0] p;
    if (rst_n && if_valid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: got if_pc %h with empty queue (t=%0t)", if_pc, $time);
      end else begin
        p = exp_q.pop_front();
        check32("if_pc", if_pc, p);
        check32("if_instr", if_instr, word_at(p));
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check32("rst_addr", ic_bus.ic_address, 32'h0);
    check32("rst_valid", 32'(if_valid), 32'h0);
    check32("rst_instr", if_instr, 32'h0);
    check32("rst_pc", if_pc, 32'h0);
    check32("rst_err", 32'(fetch_err), 32'h0);
    check_cnt(16'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming hits from reset.
    step(1, 0, 0, 0, 1, 32'h0);
    check32("t1_addr4", ic_bus.ic_address, 32'h4);
    step(1, 0, 0, 0, 1, 32'h4);
    check32("t1_addr8", ic_bus.ic_address, 32'h8);

    // Three-cycle miss at PC 8.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check32("t2_hold_addr", ic_bus.ic_address, 32'h8);
      check32("t2_bubble", 32'(if_valid), 32'h0);
    end
    step(1, 0, 0, 0, 1, 32'h8);
    check32("t2_addrC", ic_bus.ic_address, 32'hC);
    check_cnt(16'd3, 16'd1);

    // Miss timeout (MISS_TIMEOUT = 4).
    for (int i = 1; i <= 6; i++) begin
      step(0, 0, 0, 0, 0, 0);
      check32("t3_hold_addr", ic_bus.ic_address, 32'hC);
      check32("t3_err", 32'(fetch_err), (i >= 4) ? 32'h1 : 32'h0);
    end
    step(1, 0, 0, 0, 1, 32'hC);
    check32("t3_addr10", ic_bus.ic_address, 32'h10);
    check32("t3_err_sticky", 32'(fetch_err), 32'h1);
    check_cnt(16'd4, 16'd2);

    // Stall with hit at PC 0x10: IF/ID keeps PC C.
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 0, 1, 32'hC);
      check32("t4_stall_addr", ic_bus.ic_address, 32'h10);
      check32("t4_stall_valid", 32'(if_valid), 32'h1);
    end
    step(1, 0, 0, 0, 1, 32'h10);
    check32("t4_addr14", ic_bus.ic_address, 32'h14);
    check_cnt(16'd5, 16'd2);

    // Redirect during MISS plus stall.
    step(0, 0, 0, 0, 0, 0);
    check_cnt(16'd5, 16'd3);
    step(0, 1, 1, 32'h0000_0103, 0, 0);
    check32("t5_redir_addr", ic_bus.ic_address, 32'h100);
    check32("t5_redir_valid", 32'(if_valid), 32'h0);
    step(0, 0, 0, 0, 0, 0);   // FETCH -> MISS again proves state went to FETCH
    check32("t5_hold_addr", ic_bus.ic_address, 32'h100);
    check_cnt(16'd5, 16'd4);
    // Redirect and hit on the same edge: hit word dropped.
    step(1, 0, 1, 32'h0000_0200, 0, 0);
    check32("t5_redir2_addr", ic_bus.ic_address, 32'h200);
    check32("t5_redir2_valid", 32'(if_valid), 32'h0);
    step(1, 0, 0, 0, 1, 32'h200);
    check32("t5_addr204", ic_bus.ic_address, 32'h204);
    check_cnt(16'd6, 16'd4);

    // PC wrap-around.
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    check32("wrap_redir", ic_bus.ic_address, 32'hFFFF_FFFC);
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check32("wrap_addr0", ic_bus.ic_address, 32'h0);
    step(1, 0, 0, 0, 1, 32'h0);
    check32("wrap_addr4", ic_bus.ic_address, 32'h4);
    check_cnt(16'd8, 16'd4);

    // Asynchronous reset mid-MISS.
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_cnt(16'd8, 16'd5);
    #2 rst_n = 1'b0;
    #1;
    check32("t6_addr", ic_bus.ic_address, 32'h0);
    check32("t6_valid", 32'(if_valid), 32'h0);
    check32("t6_instr", if_instr, 32'h0);
    check32("t6_pc", if_pc, 32'h0);
    check32("t6_err", 32'(fetch_err), 32'h0);
    check_cnt(16'd0, 16'd0);
    @(negedge clk);
    check32("t6_addr_held", ic_bus.ic_address, 32'h0);

    check32("queue_drain", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_instr_fetch_unit
`default_nettype wire
